sha256_compress_core: RTL and testbench
=======================================

// Module: sha256_compress_core
// PURPOSE
//  SHA-256 compression engine: runs the 64 rounds over one 512-bit block and
//  produces the final working variables a..h. Sits directly upstream of the
//  H0..H7 hash-state registers (H1 etc.), which add a..h into the running hash.
//  Message words stream in one 32-bit word per cycle; the schedule is expanded internally.
// PARAMETERS
//  ROUNDS   64   round count (fixed by FIPS 180-4; exposed only for test builds)
// PORTS
//  clk        in   1    single clock, all state on posedge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    begin a block; sampled only in IDLE
//  h_in       in   256  current hash state {H0..H7}, H0 in [255:224]; loaded on start
//  msg_word   in   32   message word W[t], t=0..15, big-endian word order
//  msg_valid  in   1    msg_word valid this cycle
//  msg_ready  out  1    core consumes msg_word this cycle (valid & ready = transfer)
//  busy       out  1    high from start acceptance until done cycle inclusive
//  done       out  1    one-cycle pulse: a_out..h_out final for this block
//  a_out..h_out out 32 each  working variables a..h (registered)
// BEHAVIOUR
//  Reset: state=IDLE, round counter=0, busy=0, done=0, msg_ready=0, a_out..h_out=0,
//   schedule window cleared. Reset asserted mid-block aborts it; no done is produced.
//  States: IDLE -> ROUND -> DONE -> IDLE.
//  IDLE: start=1 at edge N loads a..h <= h_in, t <= 0, state <= ROUND.
//  ROUND, t<16: msg_ready=1; round t executes only on the edge where msg_valid=1,
//   using W=msg_word; msg_valid=0 stalls (a..h, t, window hold). msg_ready=0 for t>=16.
//  ROUND, t>=16: W = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32, one per cycle,
//   never stalls.
//  Round: T1=h+S1(e)+Ch(e,f,g)+K[t]+W; T2=S0(a)+Maj(a,b,c); all adds mod 2^32;
//   h<=g g<=f f<=e e<=d+T1 d<=c c<=b b<=a a<=T1+T2; t<=t+1.
//  After round t=ROUNDS-1 state <= DONE. No stalls: rounds at edges N+1..N+64,
//   done=1 for exactly the cycle after edge N+64; then IDLE.
//  a_out..h_out hold the final values from DONE until the next accepted start.
//  start while busy is ignored (no restart, no queueing). start in DONE cycle ignored;
//   start accepted on the first IDLE cycle after.
//  msg_valid with msg_ready=0 is ignored; the producer must hold the word.
//  h_in sampled only at start acceptance; later changes have no effect.
// STRUCTURE
//  Shared package sha256_pkg: K[0:63] table, IV H0..H7 constants,
//   functions S0/S1/s0/s1/Ch/Maj, state enum {IDLE,ROUND,DONE}.
//  Sub-module sha256_msg_schedule: 16x32 shift window; in: load word / expand enable;
//   out: W for the current round. Core holds FSM, counter and a..h datapath.
//  Adder of H(i-1)+a..h is NOT here; it belongs to the downstream hash-state registers.
// TESTING
//  1 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), h_in=IV, valid always high
//    -> after round 0 a=0x5d6aebcd e=0xfa2a4622; done at start+65 cycles;
//    a_out=0x506e3058, h_out=0x961f4894 (IV+a..h = ba7816bf..f20015ad).
//  2 Same as 1 with msg_valid low 3 cycles before W5 -> done delayed exactly 3 cycles,
//    identical a_out..h_out; msg_ready low for all t>=16.
//  3 start pulsed at round 20 and in the DONE cycle -> ignored, single done, result as 1.
//  4 rst_n low at round 30 -> busy=0, done=0, outputs 0 immediately (async); new
//    start then reproduces result of 1.
//  5 Two back-to-back blocks (start on first IDLE cycle after done), second uses
//    h_in = first hash -> a_out..h_out match software model; done pulses 66 cycles apart.
//  6 Random blocks vs. reference model, random msg_valid gaps -> all outputs match.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions and FSM state type.
// Used by the compression core and its message schedule.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] e,
                                       input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word sliding window of the message schedule.
// Passes streamed words through for t<16, expands W[t] afterwards.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_i,
    input  logic        expand_i,
    input  logic        adv_i,
    output logic [31:0] w_o
);

    // win_q[0] is W[t-16], win_q[15] is W[t-1]
    logic [31:0] win_q [16];
    logic [31:0] exp_w;

    assign exp_w = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];
    assign w_o   = expand_i ? exp_w : word_i;

    // shift the round's word into the window whenever a round executes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else if (adv_i) begin
            for (int i = 0; i < 15; i++) begin
                win_q[i] <= win_q[i + 1];
            end
            win_q[15] <= w_o;
        end
    end

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 64-round compression of one block into working vars a..h.
// Words stream in for t<16 with stall support; expansion runs after.
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] h_in,
    input  logic [31:0]  msg_word,
    input  logic         msg_valid,
    output logic         msg_ready,
    output logic         busy,
    output logic         done,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic [31:0]  e_out,
    output logic [31:0]  f_out,
    output logic [31:0]  g_out,
    output logic [31:0]  h_out
);

    state_e      state_q;
    logic [6:0]  t_q;
    logic [31:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [31:0] a_d, e_d;
    logic [31:0] w, t1, t2;
    logic        in_msg, step;

    assign in_msg = (t_q < 7'd16);
    assign step   = (state_q == ROUND) && (!in_msg || msg_valid);

    sha256_msg_schedule u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .word_i   (msg_word),
        .expand_i (!in_msg),
        .adv_i    (step),
        .w_o      (w)
    );

    assign t1  = h_q + S1(e_q) + Ch(e_q, f_q, g_q) + K[t_q[5:0]] + w;
    assign t2  = S0(a_q) + Maj(a_q, b_q, c_q);
    assign a_d = t1 + t2;
    assign e_d = d_q + t1;

    // block FSM, round counter and a..h working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= h_in;
                        t_q     <= '0;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    if (step) begin
                        h_q <= g_q;
                        g_q <= f_q;
                        f_q <= e_q;
                        e_q <= e_d;
                        d_q <= c_q;
                        c_q <= b_q;
                        b_q <= a_q;
                        a_q <= a_d;
                        t_q <= t_q + 7'd1;
                        if (t_q == 7'(ROUNDS - 1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign msg_ready = (state_q == ROUND) && in_msg;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    assign a_out = a_q;
    assign b_out = b_q;
    assign c_out = c_q;
    assign d_out = d_q;
    assign e_out = e_q;
    assign f_out = f_q;
    assign g_out = g_q;
    assign h_out = h_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed and random block tests for sha256_compress_core.
// Results are checked against an array-based FIPS 180-4 model.
module tb_sha256_compress_core;

    typedef logic [31:0] blk_t [16];
    typedef int gap_t [16];

    localparam logic [255:0] IVT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] h_in = '0;
    logic [31:0]  msg_word = '0;
    logic         msg_valid = 1'b0;
    logic         msg_ready, busy, done;
    logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
    logic [255:0] dut_res;

    int           nvec = 0;
    int           nfail = 0;
    longint       cyc = 0;
    logic [255:0] exp_q [$];
    logic [255:0] last_res = '0;
    bit           have_res = 1'b0;
    logic [31:0]  r0_a, r0_e;

    sha256_compress_core #(.ROUNDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .h_in      (h_in),
        .msg_word  (msg_word),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .busy      (busy),
        .done      (done),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out),
        .d_out     (d_out),
        .e_out     (e_out),
        .f_out     (f_out),
        .g_out     (g_out),
        .h_out     (h_out)
    );

    assign dut_res = {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // straight FIPS 180-4 compression: full 64-entry W array, then rounds
    function automatic logic [255:0] model(input logic [255:0] hin, input blk_t m);
        logic [31:0] wt [64];
        logic [31:0] v [8];
        logic [31:0] x1, x2, ch, mj;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                wt[t] = m[t];
            end else begin
                wt[t] = (ror(wt[t-2], 17) ^ ror(wt[t-2], 19) ^ (wt[t-2] >> 10))
                      + wt[t-7]
                      + (ror(wt[t-15], 7) ^ ror(wt[t-15], 18) ^ (wt[t-15] >> 3))
                      + wt[t-16];
            end
        end
        for (int t = 0; t < 64; t++) begin
            ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
            mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ch + KT[t] + wt[t];
            x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + mj;
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i];
        return r;
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // per-cycle compare: results on done, idle quiet and result hold
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                chk("busy_in_done", 256'(busy), 256'(1));
                if (exp_q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL spurious_done: got done=1 want no done (t=%0t)", $time);
                end else begin
                    last_res = exp_q.pop_front();
                    have_res = 1'b1;
                    chk("result", dut_res, last_res);
                end
            end else if (!busy) begin
                chk("idle_ready", 256'(msg_ready), 256'(0));
                if (have_res) chk("hold", dut_res, last_res);
            end
        end
    end

    task automatic run_block(input logic [255:0] hin, input blk_t w, input gap_t gap,
                             input int poke_k, input bit poke_done, input int abort_k,
                             output longint done_cyc);
        longint acc;
        int     stalls;
        stalls = 0;
        done_cyc = -1;
        exp_q.push_back(model(hin, w));
        start = 1'b1;
        h_in  = hin;
        tick();
        acc   = cyc;
        start = 1'b0;
        h_in  = ~hin;
        chk("busy_start", 256'(busy), 256'(1));
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                msg_valid = 1'b0;
                msg_word  = $urandom;
                chk("ready_stall", 256'(msg_ready), 256'(1));
                tick();
                stalls++;
            end
            msg_valid = 1'b1;
            msg_word  = w[i];
            chk("ready_word", 256'(msg_ready), 256'(1));
            tick();
            if (i == 0) begin
                r0_a = a_out;
                r0_e = e_out;
            end
        end
        msg_word = $urandom;
        for (int k = 0; k < 120; k++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            chk("ready_low", 256'(msg_ready), 256'(0));
            start = (k == poke_k);
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 256'(busy), 256'(0));
                chk("abort_done", 256'(done), 256'(0));
                chk("abort_out", dut_res, 256'(0));
                exp_q.delete();
                have_res  = 1'b0;
                start     = 1'b0;
                msg_valid = 1'b0;
                tick();
                rst_n = 1'b1;
                tick();
                done_cyc = -2;
                return;
            end
            tick();
        end
        start = 1'b0;
        msg_valid = 1'b0;
        if (done_cyc < 0) begin
            nvec++;
            nfail++;
            $display("FAIL done_timeout: got no done want done within 120 cycles");
        end else begin
            chk("latency", 256'(done_cyc - acc), 256'(64 + stalls));
        end
        if (poke_done) start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_busy", 256'(busy), 256'(0));
        chk("idle_done", 256'(done), 256'(0));
        if (poke_done) begin
            tick();
            chk("start_in_done_ignored", 256'(busy), 256'(0));
        end
    endtask

    initial begin
        blk_t         abc, rb;
        gap_t         g0, g2, gr;
        logic [255:0] m, h2, hr;
        longint       d1, d2;

        for (int i = 0; i < 16; i++) begin
            abc[i] = '0;
            g0[i]  = 0;
            g2[i]  = 0;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        g2[5]   = 3;

        // model pinned to hand-known values
        m = model(IVT, abc);
        chk("pin_a", 256'(m[255:224]), 256'(32'h506e3058));
        chk("pin_h", 256'(m[31:0]), 256'(32'h961f4894));
        chk("pin_digest", add8(IVT, m),
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        tick();
        tick();
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_ready", 256'(msg_ready), 256'(0));
        chk("rst_out", dut_res, 256'(0));
        rst_n = 1'b1;
        tick();

        // 1: "abc"
        run_block(IVT, abc, g0, -1, 1'b0, -1, d1);
        chk("round0_a", 256'(r0_a), 256'(32'h5d6aebcd));
        chk("round0_e", 256'(r0_e), 256'(32'hfa2a4622));
        chk("abc_a_out", 256'(a_out), 256'(32'h506e3058));
        chk("abc_h_out", 256'(h_out), 256'(32'h961f4894));

        // 2: three stall cycles before W5
        run_block(IVT, abc, g2, -1, 1'b0, -1, d1);

        // 3: start pokes at round 20 and in the done cycle
        run_block(IVT, abc, g0, 4, 1'b1, -1, d1);

        // 4: reset at round 30, then a clean rerun
        run_block(IVT, abc, g0, -1, 1'b0, 14, d1);
        run_block(IVT, abc, g0, -1, 1'b0, -1, d1);
        chk("after_abort_a", 256'(a_out), 256'(32'h506e3058));

        // 5: back-to-back, chained hash
        for (int i = 0; i < 16; i++) rb[i] = $urandom;
        run_block(IVT, abc, g0, -1, 1'b0, -1, d1);
        h2 = add8(IVT, model(IVT, abc));
        run_block(h2, rb, g0, -1, 1'b0, -1, d2);
        chk("b2b_spacing", 256'(d2 - d1), 256'(66));

        // 6: random blocks, random valid gaps
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) begin
                rb[i] = $urandom;
                gr[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            for (int i = 0; i < 8; i++) hr[32*i +: 32] = $urandom;
            run_block(hr, rb, gr, -1, 1'b0, -1, d1);
        end

        tick();
        if (exp_q.size() != 0) begin
            nvec++;
            nfail++;
            $display("FAIL missing_done: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
